// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing defaults and the transmit serializer states.
// The receive path takes its bit-timing constant from here as well.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 104;  // 12 MHz / 115200
  localparam int UART_FIFO_DEPTH_DEFAULT   = 16;
  localparam int UART_DATA_BITS            = 8;

  typedef enum logic [1:0] {
    UART_TX_IDLE,
    UART_TX_START,
    UART_TX_DATA,
    UART_TX_STOP
  } uart_tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_buffer.sv
// Transmit FIFO: circular buffer with wrapping pointers, a separate occupancy
// counter, full/empty flags and a registered overflow pulse for dropped pushes.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH_DEFAULT,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  input  logic                      rd_en,
  output logic [UART_DATA_BITS-1:0] rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [CW-1:0]             count,
  output logic                      overflow
);

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic                      push;
  logic                      pop;

  // Accept/pop decisions use pre-edge occupancy; a pop never makes room for a push in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset; clearing the pointers and count is enough to discard contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : uart_tx_buffer

// File: rtl/uart_tx_fifo_ser.sv
// Buffered 8N1 UART transmitter: a FIFO feeds a serializer FSM that drives tx
// from a flop. Back-to-back frames follow each other with no idle gap.
module uart_tx_fifo_ser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = UART_FIFO_DEPTH_DEFAULT,
  localparam int CW  = $clog2(FIFO_DEPTH) + 1,
  localparam int BCW = $clog2(CLKS_PER_BIT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic [CW-1:0]             fifo_count,
  output logic                      overflow,
  output logic                      busy,
  output logic                      tx
);

  uart_tx_state_e            state;
  logic [BCW-1:0]            bit_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] head;
  logic                      bit_end;
  logic                      pop;

  uart_tx_buffer #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_buffer (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  // A byte is taken from the FIFO when idle, or on the last stop-bit cycle for back-to-back frames.
  assign bit_end = (bit_cnt == BCW'(CLKS_PER_BIT - 1));
  assign pop     = !fifo_empty &&
                   ((state == UART_TX_IDLE) || (state == UART_TX_STOP && bit_end));

  // Serializer FSM; tx and busy are registered with the value for the state being entered.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= UART_TX_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        UART_TX_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= head;
            bit_cnt <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= UART_TX_START;
          end
        end
        UART_TX_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= UART_TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        UART_TX_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shift   <= shift >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= UART_TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        UART_TX_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shift <= head;
              tx    <= 1'b0;
              state <= UART_TX_START;
            end else begin
              busy  <= 1'b0;
              state <= UART_TX_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= UART_TX_IDLE;
        end
      endcase
    end
  end

endmodule : uart_tx_fifo_ser

// File: tb/tb_uart_tx_fifo_ser.sv
// Directed bench for uart_tx_fifo_ser with CLKS_PER_BIT = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo_ser;

  localparam int CPB = 4;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       busy;
  logic       tx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q [$];
  int         rx_frame_err = 0;

  uart_tx_fifo_ser #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy),
    .tx         (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line receiver: detects a start bit, samples near bit centres, discards frames cut by reset.
  initial begin : rx_monitor
    logic [7:0] d;
    logic       aborted;
    logic       start_ok;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        aborted = 1'b0;
        @(negedge clk);
        aborted  = aborted | (reset === 1'b1);
        start_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          for (int j = 0; j < CPB; j++) begin
            @(negedge clk);
            aborted = aborted | (reset === 1'b1);
          end
          d[i] = tx;
        end
        for (int j = 0; j < CPB; j++) begin
          @(negedge clk);
          aborted = aborted | (reset === 1'b1);
        end
        stop_bit = tx;
        if (!aborted) begin
          rx_q.push_back(d);
          if (!start_ok || stop_bit !== 1'b1) rx_frame_err++;
        end
      end
    end
  end

  // Wait until the serializer is idle with an empty FIFO, within a cycle budget.
  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && fifo_empty) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx, busy, fifo_empty, fifo_full, fifo_count, overflow} !== {4'b1010, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got tx/busy/empty/full/count/ovf=%b%b%b%b/%0d/%b want 1010/0/0",
               tx, busy, fifo_empty, fifo_full, fifo_count, overflow);
    end
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tx, busy, fifo_empty, fifo_count} !== {3'b101, 5'd0}) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got tx/busy/empty/count=%b%b%b/%0d want 101/0",
                 c, tx, busy, fifo_empty, fifo_count);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] exp_f;
    exp_f = {1'b1, 8'hA5, 1'b0};
    rx_q.delete();
    for (int c = 0; c <= 41; c++) begin
      wr_en   = (c == 0);
      wr_data = 8'hA5;
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if ({fifo_empty, fifo_count, tx, busy} !== {1'b0, 5'd1, 2'b10}) begin
          n_fail++;
          $display("FAIL single_push: got empty/count/tx/busy=%b/%0d/%b%b want 0/1/10",
                   fifo_empty, fifo_count, tx, busy);
        end
      end
      if (c == 1) begin
        n_checks++;
        if ({tx, busy, fifo_empty, fifo_count} !== {3'b011, 5'd0}) begin
          n_fail++;
          $display("FAIL single_pop: got tx/busy/empty/count=%b%b%b/%0d want 011/0",
                   tx, busy, fifo_empty, fifo_count);
        end
      end
      if (c % 4 == 3 && c <= 39) begin
        n_checks++;
        if (tx !== exp_f[(c-3)/4]) begin
          n_fail++;
          $display("FAIL single_bit%0d: got %b want %b", (c-3)/4, tx, exp_f[(c-3)/4]);
        end
      end
      if (c == 40) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_busy_end: got %b want 1", busy);
        end
      end
      if (c == 41) begin
        n_checks++;
        if ({busy, tx} !== 2'b01) begin
          n_fail++;
          $display("FAIL single_idle: got busy/tx=%b%b want 01", busy, tx);
        end
      end
    end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_rx: got %0d bytes first=%h want 1 byte a5", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] s;
    logic [7:0]  b [3];
    b = '{8'h00, 8'hFF, 8'h55};
    s = {1'b1, 8'h55, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    for (int c = 0; c <= 121; c++) begin
      wr_en   = (c < 3);
      wr_data = 8'h00;
      if (c < 3) wr_data = b[c];
      @(negedge clk);
      if (c % 4 == 3 && c <= 119) begin
        n_checks++;
        if (tx !== s[(c-3)/4]) begin
          n_fail++;
          $display("FAIL b2b_bit%0d: got %b want %b", (c-3)/4, tx, s[(c-3)/4]);
        end
      end
      if (c >= 1 && c <= 120) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_busy cyc %0d: got %b want 1", c, busy);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (fifo_count !== 5'd2) begin
          n_fail++;
          $display("FAIL b2b_count2: got %0d want 2", fifo_count);
        end
      end
      if (c == 41) begin
        n_checks++;
        if (fifo_count !== 5'd1) begin
          n_fail++;
          $display("FAIL b2b_count41: got %0d want 1", fifo_count);
        end
      end
      if (c == 80 || c == 81) begin
        n_checks++;
        if (fifo_empty !== (c == 81)) begin
          n_fail++;
          $display("FAIL b2b_empty cyc %0d: got %b want %b", c, fifo_empty, (c == 81));
        end
      end
      if (c == 121) begin
        n_checks++;
        if ({busy, tx} !== 2'b01) begin
          n_fail++;
          $display("FAIL b2b_idle: got busy/tx=%b%b want 01", busy, tx);
        end
      end
    end
  endtask

  task automatic test_full_overflow();
    int ov_seen;
    bit ok;
    ov_seen = 0;
    rx_q.delete();
    for (int c = 0; c <= 24; c++) begin
      wr_en   = (c == 0) || (c >= 3 && c <= 19);
      wr_data = (c == 0) ? 8'h3C : 8'(c - 3);
      @(negedge clk);
      if (overflow === 1'b1) ov_seen++;
      if (c == 2) begin
        n_checks++;
        if ({busy, fifo_empty} !== 2'b11) begin
          n_fail++;
          $display("FAIL full_midframe: got busy/empty=%b%b want 11", busy, fifo_empty);
        end
      end
      if (c >= 18 && c <= 20) begin
        n_checks++;
        if ({fifo_full, fifo_count, overflow} !== {1'b1, 5'd16, (c == 19)}) begin
          n_fail++;
          $display("FAIL full_state cyc %0d: got full/count/ovf=%b/%0d/%b want 1/16/%b",
                   c, fifo_full, fifo_count, overflow, (c == 19));
        end
      end
    end
    n_checks++;
    if (ov_seen != 1) begin
      n_fail++;
      $display("FAIL full_ovf_pulses: got %0d want 1", ov_seen);
    end
    drain(17 * 40 + 200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL full_drain: got timeout want idle");
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 17) begin
      n_fail++;
      $display("FAIL full_rx_count: got %0d want 17", rx_q.size());
    end
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== ((i == 0) ? 8'h3C : 8'(i - 1))) begin
        n_fail++;
        $display("FAIL full_rx%0d: got %h want %h", i, rx_q[i], (i == 0) ? 8'h3C : 8'(i - 1));
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    rx_q.delete();
    for (int i = 0; i < 40; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h80 + i);
      @(negedge clk);
      wr_en = 1'b0;
      if (i % 3 == 2) repeat (110) @(negedge clk);
    end
    drain(40 * 40 + 200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_drain: got timeout want idle");
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 40) begin
      n_fail++;
      $display("FAIL wrap_rx_count: got %0d want 40", rx_q.size());
    end
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== 8'(8'h80 + i)) begin
        n_fail++;
        $display("FAIL wrap_rx%0d: got %h want %h", i, rx_q[i], 8'(8'h80 + i));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    rx_q.delete();
    for (int c = 0; c <= 18; c++) begin
      wr_en   = (c <= 5);
      wr_data = 8'(8'h10 + c);
      @(negedge clk);
      if (c == 5) begin
        n_checks++;
        if (fifo_count !== 5'd5) begin
          n_fail++;
          $display("FAIL rstmid_queued: got %0d want 5", fifo_count);
        end
      end
    end
    // Data bit 3 of 0x10 is 0, so tx is low right before the reset.
    n_checks++;
    if ({busy, tx} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_bit3: got busy/tx=%b%b want 10", busy, tx);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({tx, busy, fifo_empty, fifo_count} !== {3'b101, 5'd0}) begin
      n_fail++;
      $display("FAIL rstmid_async: got tx/busy/empty/count=%b%b%b/%0d want 101/0",
               tx, busy, fifo_empty, fifo_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tx, busy, fifo_count} !== {2'b10, 5'd0}) begin
        n_fail++;
        $display("FAIL rstmid_idle cyc %0d: got tx/busy/count=%b%b/%0d want 10/0",
                 c, tx, busy, fifo_count);
      end
    end
    n_checks++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_resume: got %0d bytes want 0", rx_q.size());
    end
    wr_en   = 1'b1;
    wr_data = 8'h96;
    @(negedge clk);
    wr_en = 1'b0;
    drain(100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_drain: got timeout want idle");
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h96) begin
      n_fail++;
      $display("FAIL rstmid_new_byte: got %0d bytes first=%h want 1 byte 96", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_overflow();
    test_wrap();
    test_reset_mid_frame();
    n_checks++;
    if (rx_frame_err != 0) begin
      n_fail++;
      $display("FAIL framing: got %0d bad start/stop bits want 0", rx_frame_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1 ms want finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx_fifo_ser

// File: doc/uart_tx_fifo_ser.md
# uart_tx_fifo_ser

Buffered UART transmitter: the CPU-side or debug logic pushes bytes into a 16-entry FIFO, and a serializer sends them as 8N1 frames on the `tx` pin. It is the transmit counterpart of the existing receive path. It sits between the memory-mapped I/O decode in `memory` and the board TX pad (`_20a`), and replaces the current idle-only `tx` driver inside `uart`. All clocking is from the 12 MHz HFOSC domain.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clocks per UART bit (12 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 16: number of FIFO entries. Must be a power of 2.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `wr_en`, input, 1: push `wr_data` into the FIFO this cycle.
- `wr_data`, input, 8: byte to transmit.
- `fifo_full`, output, 1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_empty`, output, 1: FIFO holds 0 entries.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow`, output, 1: one-cycle pulse when a push is dropped.
- `busy`, output, 1: serializer is not in IDLE.
- `tx`, output, 1: serial line. Idles high.

## Operation
- **Reset values:**
  - `tx`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, `overflow`=0.
  - Read and write pointers are 0. The FSM is in IDLE.
- **FIFO:**
  - Circular buffer with wrapping read and write pointers and a separate occupancy counter.
  - A push is accepted iff `wr_en && !fifo_full`, evaluated on pre-edge state.
  - A push while full is dropped and pulses `overflow` for 1 cycle. This holds even if a pop happens in the same cycle.
  - A simultaneous accepted push and pop leaves `fifo_count` unchanged.
  - Pointers wrap from `FIFO_DEPTH-1` to 0.
- **Serializer FSM:** states IDLE, START, DATA, STOP.
  - A bit counter (0..`CLKS_PER_BIT-1`) times each bit. A 3-bit index selects the data bit. An 8-bit shift register holds the byte.
  - IDLE:
    - `tx`=1.
    - If `!fifo_empty`: pop the head into the shift register, go to START, clear the bit counter.
  - START:
    - `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with index=0.
  - DATA:
    - `tx`=shift[0], sent LSB first. Each bit lasts `CLKS_PER_BIT` cycles.
    - At the end of a bit, shift right and increment the index. After index 7, go to STOP.
  - STOP:
    - `tx`=1 for `CLKS_PER_BIT` cycles.
    - On the last STOP cycle: if `!fifo_empty`, pop and go directly to START (back-to-back frames). Otherwise go to IDLE.
- `busy` = (state != IDLE).
- `tx` is driven from a flop, so it never glitches.
- Reset asserted mid-frame aborts immediately:
  - `tx` returns high asynchronously.
  - FIFO contents are discarded (pointers and count go to 0).
  - No partial frame resumes after reset.

## Timing
- **Latency:** push at edge k into an empty FIFO with the FSM in IDLE:
  - `fifo_empty` falls after edge k.
  - The pop occurs at edge k+1.
  - `tx` goes low after edge k+1.
- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles. Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- **Occupancy:** `fifo_count` and the flags update on the edge after the push or pop.
  - `fifo_full` asserts on the edge that makes count = `FIFO_DEPTH`.
  - `fifo_empty` asserts on the edge that makes count = 0.
- **Pop timing:** the pop happens on the same edge the FSM enters START. The head byte is captured into the shift register, so the writer may push again immediately.
- `overflow` is registered. It is high during the cycle after the dropped push.

## Structure
- Shared package `uart_pkg`:
  - `UART_CLKS_PER_BIT_DEFAULT` = 104.
  - The serializer state enum: `UART_TX_IDLE`, `UART_TX_START`, `UART_TX_DATA`, `UART_TX_STOP`.
  - The RX side reuses the bit-timing constant from this package.
- Sub-module `uart_tx_buffer`: the FIFO, containing storage, pointers, count, flags and overflow.
- The top of this block holds the FSM and the baud counter only.

## Test plan
Use `CLKS_PER_BIT`=4 in simulation.
- **Reset idle:** hold `reset` for 3 cycles, then release. `tx`=1, `busy`=0, `fifo_empty`=1 and `fifo_count`=0 for 50 cycles.
- **Single byte:** push 0xA5 into an empty FIFO at edge k.
  - `tx` goes low after edge k+1.
  - Sample the bit centres: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` deasserts exactly 40 cycles after the frame start.
- **Back-to-back:** push 0x00, 0xFF, 0x55 on consecutive cycles.
  - Three contiguous 40-cycle frames with no idle gap.
  - `fifo_empty` rises when the third byte pops.
- **Full and overflow:** push 17 bytes (0x00..0x10) on consecutive cycles while the serializer is mid-frame.
  - Because one byte pops when the first frame starts, the 17th push lands after the FIFO reaches 16 entries.
  - `fifo_full`=1 and `fifo_count`=16.
  - `overflow` pulses once, and the dropped byte never appears on `tx`.
  - All other bytes are transmitted in order.
- **Wrap-around:** push and drain 40 bytes with an incrementing pattern, interleaving pushes with transmission. The bytes are received in order.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 5 bytes queued.
  - `tx`=1 immediately and `fifo_count`=0.
  - After release, `tx` stays idle until a new push.
